// File: rtl/pbs_battle_datapath.sv
// Battle datapath: player/AI HP registers, damage/heal/reload commands from the
// battle FSM, status flags, and a free-running LFSR for damage and catch variance.
module pbs_battle_datapath #(
  parameter int          HP_W         = 8,
  parameter int          P_MAX_HP     = 100,
  parameter int          AI_MAX_HP    = 100,
  parameter int          P_ATK        = 20,
  parameter int          AI_ATK       = 15,
  parameter int          HEAL_AMT     = 30,
  parameter int          CATCH_THRESH = 25,
  parameter bit          VAR_EN       = 1'b1,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load_ai_hp,
  input  logic            apply_ai_damage,
  input  logic            apply_p_damage,
  input  logic            p_heal,
  input  logic            catch,
  output logic [HP_W-1:0] p_hp,
  output logic [HP_W-1:0] ai_hp,
  output logic [HP_W-1:0] last_damage,
  output logic            ai_dead,
  output logic            p_dead,
  output logic            catch_success,
  output logic [2:0]      catch_count
);

  // Right-shift Galois form of x^8+x^6+x^5+x^4+1; maximal length, so a nonzero seed never reaches 0.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  logic [7:0]      lfsr;
  logic [7:0]      lfsr_next;
  logic [HP_W-1:0] variance;
  logic [HP_W-1:0] dmg_ai;
  logic [HP_W-1:0] dmg_p;
  logic [HP_W-1:0] ai_hp_hit;
  logic [HP_W-1:0] p_hp_hit;
  logic [HP_W:0]   heal_sum;
  logic [HP_W-1:0] p_hp_healed;

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                               input logic [HP_W-1:0] dmg);
    return (dmg >= hp) ? '0 : hp - dmg;
  endfunction

  assign lfsr_next = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? LFSR_TAPS : 8'h00);

  assign variance  = VAR_EN ? HP_W'(lfsr[2:0]) : '0;
  assign dmg_ai    = HP_W'(P_ATK) + variance;
  assign dmg_p     = HP_W'(AI_ATK) + variance;
  assign ai_hp_hit = sat_sub(ai_hp, dmg_ai);
  assign p_hp_hit  = sat_sub(p_hp, dmg_p);

  // Widened by one bit so the sum cannot wrap before the ceiling clamp.
  assign heal_sum    = {1'b0, p_hp} + (HP_W+1)'(HEAL_AMT);
  assign p_hp_healed = (heal_sum > (HP_W+1)'(P_MAX_HP)) ? HP_W'(P_MAX_HP) : heal_sum[HP_W-1:0];

  // NOTE: reset is sampled on the clock edge only, and every register below is
  // assigned with <= so all of them see the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr        <= LFSR_SEED;
      p_hp        <= HP_W'(P_MAX_HP);
      ai_hp       <= HP_W'(AI_MAX_HP);
      last_damage <= '0;
      catch_count <= '0;
    end else begin
      lfsr <= lfsr_next;

      if (load_ai_hp)           ai_hp <= HP_W'(AI_MAX_HP);
      else if (apply_ai_damage) ai_hp <= ai_hp_hit;

      // A dead player stays dead: heal only applies to nonzero HP.
      if (apply_p_damage)                   p_hp <= p_hp_hit;
      else if (p_heal && (p_hp != '0))      p_hp <= p_hp_healed;

      if (apply_ai_damage && !load_ai_hp)   last_damage <= dmg_ai;
      else if (apply_p_damage)              last_damage <= dmg_p;

      if (load_ai_hp)                       catch_count <= '0;
      else if (catch && (catch_count != 3'd7)) catch_count <= catch_count + 3'd1;
    end
  end

  assign ai_dead = (ai_hp == '0);
  assign p_dead  = (p_hp == '0);

  // Combinational so the FSM can sample the outcome in the same cycle as catch.
  assign catch_success = (ai_hp != '0) && (ai_hp <= HP_W'(CATCH_THRESH)) &&
                         (VAR_EN ? (lfsr[1:0] != 2'b00) : 1'b1);

endmodule

// File: doc/pbs_battle_datapath.md
# pbs_battle_datapath

Datapath partner of the battle control FSM. It holds both Pokémon HP registers and applies damage, heal and AI-HP reload commands issued by the FSM one cycle at a time. It returns the status flags `ai_dead`, `p_dead` and `catch_success` that drive the FSM's next-state logic. A free-running LFSR supplies damage variance and catch randomness.

## Interface
Parameters:
- `HP_W`, 8: HP and damage register width.
- `P_MAX_HP`, 100: player HP at reset; also the heal ceiling.
- `AI_MAX_HP`, 100: AI HP at reset and on `load_ai_hp`.
- `P_ATK`, 20: base damage dealt to the AI.
- `AI_ATK`, 15: base damage dealt to the player.
- `HEAL_AMT`, 30: HP restored per `p_heal`.
- `CATCH_THRESH`, 25: catch is possible only when `ai_hp` ≤ this value.
- `VAR_EN`, 1: 1 adds LFSR variance to damage and catch; 0 makes both deterministic.
- `LFSR_SEED`, 8'hA5: LFSR reset value. Must be nonzero.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: reset, synchronous, active-low. Clock is `clk`.
- `load_ai_hp` in 1: reload `ai_hp` to `AI_MAX_HP`.
- `apply_ai_damage` in 1: subtract player damage from `ai_hp`.
- `apply_p_damage` in 1: subtract AI damage from `p_hp`.
- `p_heal` in 1: add `HEAL_AMT` to `p_hp`.
- `catch` in 1: catch attempt strobe. Only counted; it does not affect HP.
- `p_hp` out HP_W: player HP register.
- `ai_hp` out HP_W: AI HP register.
- `last_damage` out HP_W: damage applied by the most recent damage command.
- `ai_dead` out 1: `ai_hp == 0`.
- `p_dead` out 1: `p_hp == 0`.
- `catch_success` out 1: catch outcome for the current cycle.
- `catch_count` out 3: number of catch attempts, saturating at 7.

## Operation
- **LFSR:** 8-bit Galois LFSR with polynomial x^8+x^6+x^5+x^4+1. It advances every cycle outside reset. Never reaches 0.
- **Variance term:** `var = VAR_EN ? lfsr[2:0] : 0`, zero-extended to HP_W.
- **Damage to AI:** `dmg_ai = P_ATK + var`. Damage to player: `dmg_p = AI_ATK + var`.
- **Saturating subtract:** if `dmg ≥ hp`, the result is 0; otherwise it is `hp − dmg`.
- **ai_hp update priority:**
  - `load_ai_hp` → `AI_MAX_HP`;
  - else `apply_ai_damage` → saturating subtract of `dmg_ai`;
  - else hold.
- **p_hp update priority:**
  - `apply_p_damage` → saturating subtract of `dmg_p`;
  - else `p_heal` with `p_hp ≠ 0` → `min(p_hp + HEAL_AMT, P_MAX_HP)`, computed at HP_W+1 bits;
  - else hold.
- **Dead player:** a dead player is never revived. `p_heal` while `p_hp == 0` is ignored.
- **last_damage:**
  - updated to `dmg_ai` on `apply_ai_damage` (unless `load_ai_hp` is also asserted);
  - otherwise updated to `dmg_p` on `apply_p_damage`;
  - holds otherwise.
  - When both damage commands are asserted in the same cycle, both HP registers update and `last_damage` takes `dmg_ai`.
- **catch_success (combinational):** `(ai_hp ≠ 0) && (ai_hp ≤ CATCH_THRESH) && (VAR_EN ? lfsr[1:0] ≠ 2'b00 : 1)`.
  - Valid every cycle, so the FSM samples it in the same cycle as `catch`.
- **catch_count:** increments on each `catch`, saturating at 7. Reloads to 0 on `load_ai_hp`.
- **Dead flags:** `ai_dead` and `p_dead` are combinational compares on the registered HP.

## Timing
- **Reset values** (first `clk` edge with `reset_n = 0`):
  - `p_hp = P_MAX_HP`, `ai_hp = AI_MAX_HP`;
  - `last_damage = 0`, `catch_count = 0`, `lfsr = LFSR_SEED`;
  - hence `ai_dead = 0`, `p_dead = 0`.
- **Reset precedence:** reset mid-command wins; the command is discarded.
- **Command latency:** a command sampled at edge N is visible on the HP outputs after edge N. The dead flags follow in the same cycle, so the FSM sees `ai_dead` one cycle after asserting `apply_ai_damage`.
- **Variance sampling:** `var` uses the LFSR value present in the command cycle, before that edge's advance.
- **No handshake:** commands are single-cycle levels, applied on every cycle they are held. The FSM guarantees one-cycle pulses.
- **Unchanged outputs:** no output changes except at `clk` edges or through the combinational flags.

## Test plan
1. **Reset.** Hold `reset_n = 0` for 2 cycles, then release → `p_hp = 100`, `ai_hp = 100`, `last_damage = 0`, `catch_count = 0`, no flags set.
2. **Deterministic damage and death** (`VAR_EN = 0`). Apply `apply_ai_damage` 5 times → `ai_hp` steps 80, 60, 40, 20, 0 and `ai_dead = 1` after the 5th edge. A 6th pulse keeps `ai_hp = 0`.
3. **Heal saturation** (`VAR_EN = 0`).
   - `apply_p_damage` → `p_hp = 85`. Then `p_heal` → `p_hp = 100`, not 115.
   - Damage `p_hp` to 10, then `p_heal` → `p_hp = 40`.
   - Drive `p_hp` to 0 (`p_dead = 1`), then `p_heal` → `p_hp` stays 0.
4. **Catch threshold** (`VAR_EN = 0`).
   - `ai_hp = 40` → `catch_success = 0`.
   - After damage to `ai_hp = 20` → `catch_success = 1`.
   - At `ai_hp = 0` → `catch_success = 0`.
   - 9 `catch` pulses → `catch_count = 7`. `load_ai_hp` → `catch_count = 0`, `ai_hp = 100`.
5. **Priority and simultaneity.**
   - `load_ai_hp` together with `apply_ai_damage` → `ai_hp = 100` and `last_damage` unchanged.
   - `apply_p_damage` together with `p_heal` at `p_hp = 100` → `p_hp = 85`.
   - Both damage commands together (`VAR_EN = 0`) → `ai_hp` −20, `p_hp` −15, `last_damage = 20`.
6. **Variance** (`VAR_EN = 1`, seed `8'hA5`).
   - Compare against a reference LFSR model for 200 cycles.
   - Every `last_damage` lies in 20–27 (player attacks) or 15–22 (AI attacks).
   - The LFSR never reads 0.
   - `reset_n` asserted mid-sequence restores `lfsr = 8'hA5` and all HP values.
